// File: rtl/rl_types.sv
// Shared types and default sizing for the race-logic alignment array.
package rl_types;

  localparam int DELAY_WIDTH   = 4;
  localparam int CFG_DEPTH_DEF = 16;
  localparam int CTR_WIDTH_DEF = 8;
  localparam int TB_LEN_DEF    = 32;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    RACE,
    TB,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, sat flags the ceiling.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign sat   = &cnt_q;
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/race_ctrl.sv
// Sequencer for one race-logic pass: load delays, time the race,
// drain traceback, then pulse done with the score.
module race_ctrl
  import rl_types::*;
#(
  parameter int CFG_DEPTH   = CFG_DEPTH_DEF,
  parameter int CTR_WIDTH   = CTR_WIDTH_DEF,
  parameter int TB_LEN      = TB_LEN_DEF,
  parameter int DELAY_WIDTH = rl_types::DELAY_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DELAY_WIDTH-1:0] cfg_indel,
  input  logic [DELAY_WIDTH-1:0] cfg_sub,
  input  logic                   arrive,
  output logic                   busy,
  output logic                   indel_shift_en,
  output logic [DELAY_WIDTH-1:0] indel_shift,
  output logic                   sub_shift_en,
  output logic [DELAY_WIDTH-1:0] sub_shift,
  output logic                   race_go,
  output logic                   tb_shift_en,
  output logic [CTR_WIDTH-1:0]   score,
  output logic                   timeout,
  output logic                   done
);

  localparam int PH_MAX = (CFG_DEPTH > TB_LEN) ? CFG_DEPTH : TB_LEN;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  if (CFG_DEPTH < 1 || TB_LEN < 1 || CTR_WIDTH < 1 ||
      DELAY_WIDTH < 1) begin : g_bad_param
    $error("race_ctrl: all parameters must be at least 1");
  end

  ctrl_state_e            state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [DELAY_WIDTH-1:0] indel_q, indel_d;
  logic [DELAY_WIDTH-1:0] sub_q, sub_d;
  logic [CTR_WIDTH-1:0]   score_q, score_d;
  logic                   tmo_q, tmo_d;
  logic [CTR_WIDTH-1:0]   cnt;
  logic                   cnt_sat;
  logic                   in_race;

  assign in_race = (state_q == RACE);

  // Counter sits at zero outside RACE so the first race cycle reads 0.
  sat_counter #(
    .WIDTH(CTR_WIDTH)
  ) u_race_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_race),
    .inc  (in_race && !arrive),
    .count(cnt),
    .sat  (cnt_sat)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    indel_d = indel_q;
    sub_d   = sub_q;
    score_d = score_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          indel_d = cfg_indel;
          sub_d   = cfg_sub;
          ph_d    = '0;
          score_d = '0;
          tmo_d   = 1'b0;
          state_d = CFG;
        end
      end
      CFG: begin
        if (ph_q == PH_W'(CFG_DEPTH - 1)) begin
          ph_d    = '0;
          state_d = RACE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      RACE: begin
        // Arrival takes priority over saturation in the same cycle.
        if (arrive) begin
          score_d = cnt;
          tmo_d   = 1'b0;
          ph_d    = '0;
          state_d = TB;
        end else if (cnt_sat) begin
          score_d = cnt;
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      TB: begin
        if (ph_q == PH_W'(TB_LEN - 1)) begin
          ph_d    = '0;
          state_d = DONE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      indel_q <= '0;
      sub_q   <= '0;
      score_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      indel_q <= indel_d;
      sub_q   <= sub_d;
      score_q <= score_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign indel_shift_en = (state_q == CFG);
  assign sub_shift_en   = (state_q == CFG);
  assign indel_shift    = (state_q == CFG) ? indel_q : '0;
  assign sub_shift      = (state_q == CFG) ? sub_q : '0;
  assign race_go        = in_race;
  assign tb_shift_en    = (state_q == TB);
  assign done           = (state_q == DONE);
  assign score          = score_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Directed and randomized passes against a cycle-timeline model
// derived from phase lengths and arrival time.
module tb_race_ctrl;

  localparam int CD = 4;
  localparam int CW = 4;
  localparam int TL = 3;
  localparam int DW = rl_types::DELAY_WIDTH;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] cfg_indel;
  logic [DW-1:0] cfg_sub;
  logic          arrive;
  logic          busy;
  logic          indel_shift_en;
  logic [DW-1:0] indel_shift;
  logic          sub_shift_en;
  logic [DW-1:0] sub_shift;
  logic          race_go;
  logic          tb_shift_en;
  logic [CW-1:0] score;
  logic          timeout;
  logic          done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  race_ctrl #(
    .CFG_DEPTH  (CD),
    .CTR_WIDTH  (CW),
    .TB_LEN     (TL),
    .DELAY_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_indel     (cfg_indel),
    .cfg_sub       (cfg_sub),
    .arrive        (arrive),
    .busy          (busy),
    .indel_shift_en(indel_shift_en),
    .indel_shift   (indel_shift),
    .sub_shift_en  (sub_shift_en),
    .sub_shift     (sub_shift),
    .race_go       (race_go),
    .tb_shift_en   (tb_shift_en),
    .score         (score),
    .timeout       (timeout),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".ien"}, 32'(indel_shift_en), 0);
    chk({tag, ".sen"}, 32'(sub_shift_en), 0);
    chk({tag, ".ival"}, 32'(indel_shift), 0);
    chk({tag, ".sval"}, 32'(sub_shift), 0);
    chk({tag, ".go"}, 32'(race_go), 0);
    chk({tag, ".tben"}, 32'(tb_shift_en), 0);
    chk({tag, ".score"}, 32'(score), 0);
    chk({tag, ".tmo"}, 32'(timeout), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  // ak: race cycle index where arrive rises (>SMAX means never).
  // hold: arrive high from before start. noise: spurious starts and
  // cfg churn. rst_tb2: reset in the second traceback cycle.
  task automatic run_pass(input string tag, input int ak, input bit hold,
                          input bit noise, input bit rst_tb2);
    logic [DW-1:0] vi, vs;
    int tmo, sc, rlen, done_c, rst_c;
    bit in_cfg, in_race, in_tb;
    vi = DW'($urandom);
    vs = DW'($urandom);
    if (tag == "normal") begin
      vi = DW'(2);
      vs = DW'(5);
    end
    tmo = (ak > SMAX) ? 1 : 0;
    sc = tmo ? SMAX : ak;
    rlen = sc + 1;
    done_c = tmo ? (CD + 1 + rlen) : (CD + 1 + rlen + TL);
    rst_c = rst_tb2 ? (CD + 2 + rlen) : -1;
    @(posedge clk);
    #1;
    cfg_indel = vi;
    cfg_sub = vs;
    start = 1'b1;
    arrive = hold;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      if (rst_c > 0 && c == rst_c + 1) begin
        chk_zero({tag, ".rst"});
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      in_cfg = (c >= 1 && c <= CD);
      in_race = (c > CD && c <= CD + rlen);
      in_tb = (tmo == 0) && (c > CD + rlen) && (c <= CD + rlen + TL);
      chk({tag, ".busy"}, 32'(busy), 32'(c <= done_c));
      chk({tag, ".ien"}, 32'(indel_shift_en), 32'(in_cfg));
      chk({tag, ".sen"}, 32'(sub_shift_en), 32'(in_cfg));
      chk({tag, ".ival"}, 32'(indel_shift), in_cfg ? 32'(vi) : 0);
      chk({tag, ".sval"}, 32'(sub_shift), in_cfg ? 32'(vs) : 0);
      chk({tag, ".go"}, 32'(race_go), 32'(in_race));
      chk({tag, ".tben"}, 32'(tb_shift_en), 32'(in_tb));
      chk({tag, ".done"}, 32'(done), 32'(c == done_c));
      if (c <= CD) begin
        chk({tag, ".scoreclr"}, 32'(score), 0);
        chk({tag, ".tmoclr"}, 32'(timeout), 0);
      end
      if (c >= done_c) begin
        chk({tag, ".score"}, 32'(score), 32'(sc));
        chk({tag, ".tmo"}, 32'(timeout), 32'(tmo));
      end
      start = noise && (c == 2 || c == CD + 2 || c == done_c);
      if (noise) begin
        cfg_indel = DW'($urandom);
        cfg_sub = DW'($urandom);
      end
      arrive = hold || (c > CD && (c - CD - 1) >= ak);
      rst = (c == rst_c);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_indel = '0;
    cfg_sub = '0;
    arrive = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("idle");

    run_pass("normal", 6, 1'b0, 1'b0, 1'b0);
    run_pass("immediate", 0, 1'b1, 1'b0, 1'b0);
    arrive = 1'b0;
    run_pass("timeout", 1000, 1'b0, 1'b0, 1'b0);
    run_pass("coincide", SMAX, 1'b0, 1'b0, 1'b0);
    run_pass("ignored", 3, 1'b0, 1'b1, 1'b0);
    run_pass("midrst", 2, 1'b0, 1'b0, 1'b1);
    run_pass("afterrst", 5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_pass("rand", int'($urandom_range(0, SMAX + 4)), 1'b0,
               1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
